dmem_bridge: RTL
================

Name: dmem_bridge

Overview:
- Sits directly downstream of the core's MEM stage, between the datapath's data-memory outputs and a variable-latency data bus.
- Converts each load or store in MEM into one valid/ready bus request followed by a response.
- Holds the pipeline with `mem_stall` until the response arrives, then returns the raw read word on `RD_data`; byte extraction stays in the core.
- A watchdog ends any access that hangs.

Parameters:
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before the access is forced to complete with an error (range 1..65535).
- CNT_W, 16, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- MemWriteM  input  1  MEM-stage instruction is a store
- MemReadM  input  1  MEM-stage instruction is a load
- ALUResultM  input  32  byte address of the access
- WriteDataM  input  32  store data, already lane-aligned by the core
- byteEnable  input  4  store byte lanes from the core
- RD_data  output  32  read word returned to the core's load extender
- mem_stall  output  1  to hazard unit; freezes the whole pipeline while high
- bus_err  output  1  one-cycle pulse: the access ended by timeout
- bus_req_valid  output  1  request valid
- bus_req_ready  input  1  bus accepts request
- bus_we  output  1  1 = write, 0 = read
- bus_addr  output  32  word-aligned address {ALUResultM[31:2],2'b00}
- bus_wdata  output  32  write data
- bus_wstrb  output  4  write strobes; 4'b0000 for reads
- bus_rsp_valid  input  1  response / write acknowledge, one cycle
- bus_rsp_rdata  input  32  read data, valid with bus_rsp_valid

Behaviour:
- Reset values:
  - State IDLE, watchdog count 0.
  - bus_req_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0.
  - RD_data=0, bus_err=0.
- Access present: `acc = MemReadM | MemWriteM`.
  - If both MemReadM and MemWriteM are high, the access is treated as a store.
- mem_stall is combinational: `acc & (state != DONE)`.
  - It is high in the same cycle a new access appears in IDLE.
  - The MEM inputs are therefore frozen by the core until DONE.
- FSM:
  - IDLE:
    - If acc: capture bus_we, bus_addr, bus_wdata and bus_wstrb (byteEnable for stores, 0 for loads) into registers; go to REQ.
    - Otherwise stay in IDLE with mem_stall=0.
  - REQ:
    - bus_req_valid=1; all request fields are held stable.
    - On bus_req_valid & bus_req_ready, go to WAIT; bus_req_valid drops next cycle.
    - A response in the same cycle as acceptance is not legal on this bus. Any bus_rsp_valid seen in REQ is ignored.
  - WAIT:
    - On bus_rsp_valid: for reads, latch bus_rsp_rdata into RD_data; for writes, RD_data is unchanged. Go to DONE.
  - DONE:
    - mem_stall=0, so the pipeline advances at the end of this cycle.
    - RD_data holds the response; it remains held until the next read response or a timeout.
    - Unconditionally go to IDLE; the next MEM instruction is seen in IDLE on the following cycle. No double issue of the same access is possible.
- Latency:
  - Zero-wait bus (ready in REQ, response the cycle after acceptance): mem_stall high for 3 cycles (IDLE, REQ, WAIT).
  - The pipeline advances on the 4th edge after the access appears.
- Watchdog:
  - Counter clears in IDLE and increments every cycle in REQ or WAIT.
  - When the count reaches TIMEOUT-1 with no completion, the next state is DONE. bus_err pulses for one cycle with the DONE cycle, RD_data=0 for reads, and bus_req_valid deasserts.
  - A late bus_rsp_valid arriving after that, in DONE or IDLE, is ignored.
  - If completion and timeout occur in the same cycle, completion wins and bus_err stays 0.
- Reset mid-transaction: next cycle is IDLE with bus_req_valid=0. Stale responses after reset are ignored.
- No outstanding-request overlap: at most one transaction in flight.
- Misalignment checks are not performed here.

Test Plan:
1. Load from ALUResultM=0x0000_1006, MemReadM=1; bus ready immediately, rsp_valid next cycle with rdata=0xDEADBEEF -> bus_addr=0x0000_1004, bus_wstrb=0, bus_we=0; mem_stall high exactly 3 cycles; RD_data=0xDEADBEEF in DONE; exactly one bus_req_valid handshake.
2. Store sb with WriteDataM=0x0000_AB00, byteEnable=4'b0010, ALUResultM=0x20; bus_req_ready low for 4 cycles -> bus_req_valid held 5 cycles with fields stable (addr 0x20, wstrb 0010, wdata 0x0000_AB00, we=1); ack after 2 more cycles -> mem_stall drops in DONE; RD_data unchanged.
3. Back-to-back load then store in consecutive MEM instructions -> two distinct handshakes, IDLE visited between them, no duplicated request for the first access.
4. TIMEOUT=8; load with bus_req_ready stuck low -> DONE reached after 8 cycles in REQ; bus_err=1 for one cycle; RD_data=0; bus_req_valid=0 afterwards; a late rsp_valid with 0x1234_5678 leaves RD_data=0.
5. Reset asserted while in WAIT -> next cycle state IDLE, bus_req_valid=0, RD_data=0, mem_stall=0 if acc is low; subsequent rsp_valid is ignored.
6. No access (MemReadM=MemWriteM=0) for 20 cycles -> bus_req_valid and mem_stall stay 0, bus_err never pulses.

Source files
------------

// File: rtl/dmem_bridge.sv
// MEM-stage data memory bridge: turns each load/store into one valid/ready bus
// request plus a response, stalling the pipeline until the access completes.
module dmem_bridge #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  byteEnable,
    output logic [31:0] RD_data,
    output logic        mem_stall,
    output logic        bus_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] wdCnt;
    logic             acc;
    logic             timeoutHit;
    logic             rspDone;
    logic             unusedAddrLsb;

    assign acc           = MemReadM | MemWriteM;
    assign unusedAddrLsb = ^ALUResultM[1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState     = state;
        bus_req_valid = 1'b0;
        mem_stall     = acc && (state != DONE);
        timeoutHit    = 1'b0;
        rspDone       = 1'b0;
        case (state)
            IDLE: if (acc) nextState = REQ;
            REQ: begin
                bus_req_valid = 1'b1;
                // Only a response counts as completion, so the watchdog beats a
                // handshake landing on the last allowed REQ cycle.
                if (wdCnt == WD_LAST) begin
                    timeoutHit = 1'b1;
                    nextState  = DONE;
                end else if (bus_req_ready) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (bus_rsp_valid) begin
                    rspDone   = 1'b1;
                    nextState = DONE;
                end else if (wdCnt == WD_LAST) begin
                    timeoutHit = 1'b1;
                    nextState  = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdCnt     <= '0;
            bus_err   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
            RD_data   <= '0;
        end else begin
            if (state == REQ || state == WAIT) wdCnt <= wdCnt + CNT_W'(1);
            else                               wdCnt <= '0;
            bus_err <= timeoutHit;
            // A simultaneous read+write is issued as a store.
            if (state == IDLE && acc) begin
                bus_we    <= MemWriteM;
                bus_addr  <= {ALUResultM[31:2], 2'b00};
                bus_wdata <= WriteDataM;
                bus_wstrb <= MemWriteM ? byteEnable : 4'b0000;
            end
            if (rspDone && !bus_we)         RD_data <= bus_rsp_rdata;
            else if (timeoutHit && !bus_we) RD_data <= '0;
        end
    end

endmodule
